// File: rtl/winograd_kernel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : winograd_kernel_scheduler
// Streams KxK filter taps from weight memory into the per-channel kernel slots
// of the Winograd core. Optional build macro: WINOGRAD_KSCHED_PREFETCH_EN.
// Revision : 1.0
// ============================================================================
module winograd_kernel_scheduler #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int N_CHANNELS  = 3,
  parameter int N_KERNELS   = 64,
  parameter int KERNEL_SIZE = 4,
  parameter int BASE_ADDR   = 0
) (
  input  logic                                                       clock_i,
  input  logic                                                       reset_i,
  input  logic                                                       start_i,
  input  logic [ADDR_WIDTH-1:0]                                      n_windows_i,
  output logic                                                       mem_rd_o,
  output logic [ADDR_WIDTH-1:0]                                      mem_addr_o,
  input  logic [DATA_WIDTH-1:0]                                      mem_data_i,
  output logic [N_CHANNELS*KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0] kernel_o,
  output logic [N_CHANNELS-1:0]                                      kernel_valid_o,
  input  logic [N_CHANNELS-1:0]                                      hold_kernel_i,
  output logic                                                       busy_o,
  output logic                                                       done_o
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int KN_W  = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
  localparam int TAP_W = (KK > 1) ? $clog2(KK) : 1;
  localparam int IDX_W = (N_CHANNELS * KK > 1) ? $clog2(N_CHANNELS * KK) : 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_FREE = 3'd1;
  localparam logic [2:0] ST_FETCH     = 3'd2;
  localparam logic [2:0] ST_CAPTURE   = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  logic [2:0]            state;
  logic [CH_W-1:0]       ch;
  logic [KN_W-1:0]       kern;
  logic [ADDR_WIDTH-1:0] windows;
  logic [TAP_W-1:0]      tap;
  logic                  rd_d;
  logic [TAP_W-1:0]      tap_d;
  logic [N_CHANNELS-1:0] hold_d;

  logic [N_CHANNELS-1:0] consume;
  logic                  ch_wrap;
  logic                  kern_wrap;
  logic                  last_slot;
  logic                  slot_free;
  logic [CH_W-1:0]       ch_next;
  logic [KN_W-1:0]       kern_next;
  logic [IDX_W-1:0]      slot_base;

`ifdef WINOGRAD_KSCHED_PREFETCH_EN
  logic [KK-1:0][DATA_WIDTH-1:0] stage;
`endif

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [KN_W-1:0] k,
                                                    input logic [CH_W-1:0] c,
                                                    input logic [TAP_W-1:0] t);
    logic [31:0] a;
    a = 32'(BASE_ADDR) + (32'(k) * 32'(N_CHANNELS) + 32'(c)) * 32'(KK) + 32'(t);
    return a[ADDR_WIDTH-1:0];
  endfunction

  // A slot is consumed on the falling edge of the core's hold while it is valid.
  assign consume   = kernel_valid_o & ~hold_kernel_i & hold_d;
  assign ch_wrap   = (ch == CH_W'(N_CHANNELS - 1));
  assign kern_wrap = (kern == KN_W'(N_KERNELS - 1));
  assign last_slot = ch_wrap & kern_wrap & (windows == ADDR_WIDTH'(1));
  assign slot_free = ~kernel_valid_o[ch];
  assign ch_next   = ch_wrap ? '0 : ch + 1'b1;
  assign kern_next = ch_wrap ? (kern_wrap ? '0 : kern + 1'b1) : kern;
  assign slot_base = IDX_W'(ch) * IDX_W'(KK);
  assign busy_o    = (state != ST_IDLE);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= ST_IDLE;
      ch             <= '0;
      kern           <= '0;
      windows        <= '0;
      tap            <= '0;
      rd_d           <= 1'b0;
      tap_d          <= '0;
      hold_d         <= '0;
      mem_rd_o       <= 1'b0;
      mem_addr_o     <= '0;
      kernel_o       <= '0;
      kernel_valid_o <= '0;
      done_o         <= 1'b0;
`ifdef WINOGRAD_KSCHED_PREFETCH_EN
      stage          <= '0;
`endif
    end else begin
      done_o         <= 1'b0;
      hold_d         <= hold_kernel_i;
      rd_d           <= mem_rd_o;
      tap_d          <= tap;
      kernel_valid_o <= kernel_valid_o & ~consume;

      // Read data lands one cycle after its strobe; slot index still refers to ch.
      if (rd_d) begin
`ifdef WINOGRAD_KSCHED_PREFETCH_EN
        stage[tap_d] <= mem_data_i;
`else
        kernel_o[slot_base + IDX_W'(tap_d)] <= mem_data_i;
`endif
      end

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (n_windows_i != '0) begin
              windows <= n_windows_i;
              ch      <= '0;
              kern    <= '0;
`ifdef WINOGRAD_KSCHED_PREFETCH_EN
              state      <= ST_FETCH;
              mem_rd_o   <= 1'b1;
              mem_addr_o <= addr_of('0, '0, '0);
              tap        <= '0;
`else
              state   <= ST_WAIT_FREE;
`endif
            end else begin
              done_o <= 1'b1;
            end
          end
        end

        ST_FETCH: begin
          if (tap == TAP_W'(KK - 1)) begin
            mem_rd_o <= 1'b0;
            state    <= ST_CAPTURE;
          end else begin
            tap        <= tap + 1'b1;
            mem_addr_o <= addr_of(kern, ch, tap + 1'b1);
          end
        end

`ifdef WINOGRAD_KSCHED_PREFETCH_EN
        ST_CAPTURE: begin
          state <= ST_WAIT_FREE;
        end

        // Staging is full: publish it as soon as the target slot frees up,
        // then immediately start fetching the following kernel.
        ST_WAIT_FREE: begin
          if (slot_free) begin
            for (int t = 0; t < KK; t++) begin
              kernel_o[slot_base + IDX_W'(t)] <= stage[t];
            end
            kernel_valid_o[ch] <= 1'b1;
            ch   <= ch_next;
            kern <= kern_next;
            if (ch_wrap && kern_wrap) begin
              windows <= windows - 1'b1;
            end
            if (last_slot) begin
              state <= ST_DRAIN;
            end else begin
              state      <= ST_FETCH;
              mem_rd_o   <= 1'b1;
              mem_addr_o <= addr_of(kern_next, ch_next, '0);
              tap        <= '0;
            end
          end
        end
`else
        ST_CAPTURE: begin
          kernel_valid_o[ch] <= 1'b1;
          ch   <= ch_next;
          kern <= kern_next;
          if (ch_wrap && kern_wrap) begin
            windows <= windows - 1'b1;
          end
          state <= last_slot ? ST_DRAIN : ST_WAIT_FREE;
        end

        ST_WAIT_FREE: begin
          if (slot_free) begin
            state      <= ST_FETCH;
            mem_rd_o   <= 1'b1;
            mem_addr_o <= addr_of(kern, ch, '0);
            tap        <= '0;
          end
        end
`endif

        ST_DRAIN: begin
          if (kernel_valid_o == '0) begin
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_winograd_kernel_scheduler.sv
`default_nettype none
// Testbench for winograd_kernel_scheduler: memory model mem[a]=a, core model
// with programmable hold time, scoreboards on read addresses and slot contents.
module tb_winograd_kernel_scheduler;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int NCH  = 2;
  localparam int NK   = 2;
  localparam int KS   = 4;
  localparam int KK   = KS * KS;
  localparam int BASE = 'h100;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic [AW-1:0]             n_windows = '0;
  logic                      mem_rd;
  logic [AW-1:0]             mem_addr;
  logic [DW-1:0]             mem_data = '0;
  logic [NCH*KK-1:0][DW-1:0] kernel;
  logic [NCH-1:0]            kernel_valid;
  logic [NCH-1:0]            hold = '0;
  logic                      busy;
  logic                      done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic           core_en = 1'b0;
  logic           mon_en  = 1'b0;
  int             core_delay[NCH];
  int             cnt[NCH];
  logic [AW-1:0]  addr_q[$];
  logic [DW-1:0]  slot_q0[$];
  logic [DW-1:0]  slot_q1[$];
  logic [AW-1:0]  exp_a;
  logic [DW-1:0]  exp_base;
  bit             slot_ok;
  bit             have_exp;

  winograd_kernel_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CHANNELS(NCH),
    .N_KERNELS(NK), .KERNEL_SIZE(KS), .BASE_ADDR(BASE)
  ) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .n_windows_i(n_windows),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .kernel_o(kernel), .kernel_valid_o(kernel_valid), .hold_kernel_i(hold),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Weight memory: data equals address, garbage when no read was issued.
  always @(posedge clk) mem_data <= mem_rd ? DW'(mem_addr) : 32'hDEAD_BEEF;

  always @(negedge clk) begin : addr_mon
    if (mon_en && !rst && mem_rd) begin
      total_cnt++;
      if (addr_q.size() == 0) begin
        $display("FAIL rd_addr: got read of %h, required no read", mem_addr);
      end else begin
        exp_a = addr_q.pop_front();
        if (mem_addr !== exp_a) $display("FAIL rd_addr: got %h, required %h", mem_addr, exp_a);
        else pass_cnt++;
      end
    end
  end

  // Core model: latches a new kernel, holds it core_delay cycles, then releases.
  always @(negedge clk) begin : core_model
    if (rst) begin
      hold = '0;
      for (int c = 0; c < NCH; c++) cnt[c] = 0;
    end else if (core_en) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c]) begin
          cnt[c]--;
          if (cnt[c] <= 0) hold[c] = 1'b0;
        end else if (kernel_valid[c]) begin
          total_cnt++;
          have_exp = 1'b0;
          if (c == 0 && slot_q0.size() != 0) begin exp_base = slot_q0.pop_front(); have_exp = 1'b1; end
          if (c == 1 && slot_q1.size() != 0) begin exp_base = slot_q1.pop_front(); have_exp = 1'b1; end
          if (!have_exp) begin
            $display("FAIL slot%0d: got kernel tap0 %h, required no kernel", c, kernel[c*KK]);
          end else begin
            slot_ok = 1'b1;
            for (int t = 0; t < KK; t++)
              if (kernel[c*KK+t] !== exp_base + DW'(t)) slot_ok = 1'b0;
            if (slot_ok) pass_cnt++;
            else $display("FAIL slot%0d: got taps %h..%h, required %h..%h", c,
                          kernel[c*KK], kernel[c*KK+KK-1], exp_base, exp_base + DW'(KK-1));
          end
          hold[c] = 1'b1;
          cnt[c]  = core_delay[c];
        end
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; core_en = 1'b0; mon_en = 1'b0; start = 1'b0; n_windows = '0;
    addr_q.delete(); slot_q0.delete(); slot_q1.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_expect(input int nw, input int nslots);
    int s;
    s = 0;
    for (int w = 0; w < nw; w++)
      for (int k = 0; k < NK; k++)
        for (int c = 0; c < NCH; c++) begin
          if (s < nslots) begin
            for (int t = 0; t < KK; t++) addr_q.push_back(AW'(BASE + (k*NCH + c)*KK + t));
            if (c == 0) slot_q0.push_back(DW'(BASE + (k*NCH + c)*KK));
            else        slot_q1.push_back(DW'(BASE + (k*NCH + c)*KK));
          end
          s++;
        end
  endtask

  task automatic pulse_start(input logic [AW-1:0] n);
    @(negedge clk);
    start = 1'b1; n_windows = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    int waited;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (mem_rd !== 1'b0) $display("FAIL rst_rd: got %b, required 0", mem_rd); else pass_cnt++;
    total_cnt++; if (mem_addr !== '0) $display("FAIL rst_addr: got %h, required 0", mem_addr); else pass_cnt++;
    total_cnt++; if (kernel_valid !== '0) $display("FAIL rst_valid: got %b, required 0", kernel_valid); else pass_cnt++;
    total_cnt++; if (kernel !== '0) $display("FAIL rst_kernel: got nonzero taps, required all 0"); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_busy_done: got %b%b, required 00", busy, done); else pass_cnt++;
    // Reset asserted while a fetch is in flight.
    rst = 1'b0;
    pulse_start(1);
    waited = 0;
    while (mem_rd !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    total_cnt++; if (mem_rd !== 1'b1) $display("FAIL mid_fetch_start: got rd %b, required 1", mem_rd); else pass_cnt++;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++; if (mem_rd !== 1'b0 || mem_addr !== '0) $display("FAIL mid_rst_mem: got rd %b addr %h, required 0 0", mem_rd, mem_addr); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (kernel !== '0) $display("FAIL mid_rst_kernel: got tap0 %h, required all 0", kernel[0]); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || kernel_valid !== '0 || done !== 1'b0) $display("FAIL mid_rst_ctl: got busy %b valid %b done %b, required 0", busy, kernel_valid, done); else pass_cnt++;
  endtask

  task automatic run_until_done(input int budget, input int starts_at0, input int starts_at1, output int done_cnt);
    bit seen;
    seen = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin done_cnt++; seen = 1'b1; end
      start = (i == starts_at0 || i == starts_at1);
      n_windows = start ? AW'(7) : n_windows;
    end
    start = 1'b0;
    repeat (10) begin @(negedge clk); if (done) done_cnt++; end
  endtask

  task automatic test_sweep;
    int dc;
    do_reset();
    core_delay[0] = 5; core_delay[1] = 5;
    core_en = 1'b1; mon_en = 1'b1;
    push_expect(1, NK*NCH);
    pulse_start(1);
    run_until_done(3000, -1, -1, dc);
    total_cnt++; if (dc != 1) $display("FAIL sweep_done: got %0d pulses, required 1", dc); else pass_cnt++;
    total_cnt++; if (addr_q.size() != 0 || slot_q0.size() != 0 || slot_q1.size() != 0)
      $display("FAIL sweep_drain: got %0d/%0d/%0d left, required 0", addr_q.size(), slot_q0.size(), slot_q1.size()); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL sweep_idle: got busy %b, required 0", busy); else pass_cnt++;
  endtask

  task automatic test_stall;
    logic [NCH*KK-1:0][DW-1:0] snap;
    do_reset();
    mon_en = 1'b1;
    push_expect(1, NCH);
    pulse_start(1);
    repeat (100) @(negedge clk);
    total_cnt++; if (kernel_valid !== 2'b11) $display("FAIL stall_valid: got %b, required 11", kernel_valid); else pass_cnt++;
    total_cnt++; if (addr_q.size() != 0) $display("FAIL stall_reads: got %0d reads missing, required 0", addr_q.size()); else pass_cnt++;
    total_cnt++; if (kernel[0] !== DW'(BASE) || kernel[2*KK-1] !== DW'(BASE + 2*KK - 1))
      $display("FAIL stall_taps: got %h %h, required %h %h", kernel[0], kernel[2*KK-1], BASE, BASE + 2*KK - 1); else pass_cnt++;
    snap = kernel;
    repeat (60) @(negedge clk);
    total_cnt++; if (kernel !== snap) $display("FAIL stall_stable: got tap0 %h, required %h", kernel[0], snap[0]); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL stall_busy: got %b, required 1", busy); else pass_cnt++;
  endtask

  task automatic test_multi_window;
    int dc;
    do_reset();
    core_delay[0] = 3; core_delay[1] = 7;
    core_en = 1'b1; mon_en = 1'b1;
    push_expect(3, 3*NK*NCH);
    pulse_start(3);
    run_until_done(6000, 40, 150, dc);
    total_cnt++; if (dc != 1) $display("FAIL multi_done: got %0d pulses, required 1", dc); else pass_cnt++;
    total_cnt++; if (addr_q.size() != 0 || slot_q0.size() != 0 || slot_q1.size() != 0)
      $display("FAIL multi_drain: got %0d/%0d/%0d left, required 0", addr_q.size(), slot_q0.size(), slot_q1.size()); else pass_cnt++;
  endtask

  task automatic test_zero_windows;
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1; n_windows = '0;
    @(negedge clk);
    start = 1'b0;
    total_cnt++; if (done !== 1'b1) $display("FAIL zero_done: got %b, required 1", done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b, required 0", busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b, required 0", done); else pass_cnt++;
    repeat (20) @(negedge clk);
  endtask

`ifdef WINOGRAD_KSCHED_PREFETCH_EN
  task automatic test_prefetch_refill;
    logic [NCH-1:0] prev;
    logic [NCH-1:0] pend;
    int falls[NCH];
    bit seen;
    do_reset();
    core_delay[0] = 60; core_delay[1] = 90;
    core_en = 1'b1; mon_en = 1'b1;
    push_expect(1, NK*NCH);
    pulse_start(1);
    prev = '0; pend = '0; falls[0] = 0; falls[1] = 0; seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (pend[c]) begin
          total_cnt++;
          if (kernel_valid[c] !== 1'b1) $display("FAIL pf_refill%0d: got valid %b, required 1", c, kernel_valid[c]);
          else pass_cnt++;
          pend[c] = 1'b0;
        end
        if (prev[c] && !kernel_valid[c]) begin
          falls[c]++;
          if (falls[c] == 1) pend[c] = 1'b1;
        end
      end
      prev = kernel_valid;
      if (done) seen = 1'b1;
    end
    total_cnt++; if (!seen || falls[0] != NK || falls[1] != NK)
      $display("FAIL pf_sweep: got done %b falls %0d/%0d, required 1 %0d/%0d", seen, falls[0], falls[1], NK, NK); else pass_cnt++;
    total_cnt++; if (addr_q.size() != 0 || slot_q0.size() != 0 || slot_q1.size() != 0)
      $display("FAIL pf_drain: got %0d/%0d/%0d left, required 0", addr_q.size(), slot_q0.size(), slot_q1.size()); else pass_cnt++;
  endtask
`endif

  initial begin
    core_delay[0] = 5; core_delay[1] = 5;
    test_reset();
    test_sweep();
    test_stall();
    test_multi_window();
    test_zero_windows();
`ifdef WINOGRAD_KSCHED_PREFETCH_EN
    test_prefetch_refill();
`endif
    mon_en = 1'b0; core_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
